spatial_fold_scheduler: RTL and testbench
=========================================

Name: spatial_fold_scheduler

Overview:
- Sequences one feature sample through spatial_encoder.
- Accepts a packed vector of quantized channel levels and generates item memory (IM) and continuous item memory (CIM) read addresses in fold-major order.
- Streams the returned folds to the encoder with that block's start-then-free-running timing: one handshake, then one beat per cycle, no backpressure.
- Sits between the feature quantizer and spatial_encoder; it owns the IM/CIM ROM read ports.

Parameters:
NUM_CHANNEL, 214, channels per sample
NUM_FOLDS, 8, folds per hypervector
FOLD_WIDTH, 256, bits per fold (HV_DIMENSION = NUM_FOLDS*FOLD_WIDTH)
NUM_LEVELS, 21, quantization levels per channel
LEVEL_WIDTH, 5, bits per level code, clog2(NUM_LEVELS)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
feat_valid  in  1  sample offered
feat_ready  out  1  sample slot free
feat_levels  in  NUM_CHANNEL*LEVEL_WIDTH  level of channel c at bits [c*LEVEL_WIDTH +: LEVEL_WIDTH]
im_rd_en  out  1  IM read strobe
im_addr  out  clog2(NUM_CHANNEL*NUM_FOLDS)  channel*NUM_FOLDS + fold
im_data  in  FOLD_WIDTH  IM fold, registered, valid 1 cycle after strobe, held while rd_en=0
cim_rd_en  out  1  CIM read strobe, always equal to im_rd_en
cim_addr  out  clog2(NUM_LEVELS*NUM_FOLDS)  level*NUM_FOLDS + fold
cim_data  in  FOLD_WIDTH  CIM fold, same timing as im_data
enc_din_valid  out  1  first-beat valid to encoder
enc_din_ready  in  1  encoder idle
enc_im  out  FOLD_WIDTH  equals im_data
enc_cim  out  FOLD_WIDTH  equals cim_data
busy  out  1  state != IDLE

Behaviour:
- Two sample registers:
  - active: the sample being streamed.
  - pending: one-deep prefetch slot.
- feat_ready = !pending_full.
- On feat fire: load active if IDLE and active is empty, else load pending.
- Beat order: fold f outer (0..NUM_FOLDS-1), channel c inner (0..NUM_CHANNEL-1). Total T = NUM_CHANNEL*NUM_FOLDS beats.
- Beat counter width: clog2(T).
- Address generation is arithmetic. Do not use concatenation unless the widths are powers of two.
- States:
  - IDLE: active empty. On feat fire go to PRIME.
  - PRIME: one cycle. rd_en=1, addresses for beat 0. Go to OFFER.
  - OFFER: enc_din_valid=1, data is beat 0.
    - rd_en = enc_din_ready, with addresses for beat 1.
    - On enc_din_ready go to STREAM with beat=1; else hold (memory output is stable).
  - STREAM: enc_din_valid=0. Each cycle the memory output is beat n.
    - rd_en=1 for beat n+1 while n+1<T.
    - When n=T-1, the sample is complete:
      - If pending is full: move pending to active, clear pending, go to PRIME.
      - Else: clear active, go to IDLE.
- enc_din_ready is sampled only in OFFER. The encoder consumes beats 1..T-1 unconditionally on consecutive cycles, so STREAM never stalls.
- Latency:
  - Feature fire (idle) to enc_din_valid: 2 cycles.
  - Beat 0 handshake to last beat: T-1 cycles.
  - Back-to-back samples: 2-cycle gap (PRIME, OFFER) between the last beat and the next offer.
- Simultaneous events: a feat fire on the completion cycle with pending empty goes to pending and is promoted next cycle. Net effect: active is reloaded and the FSM enters PRIME.
- Reset (any time, including mid-stream):
  - State returns to IDLE; active and pending are cleared.
  - enc_din_valid=0, im_rd_en=cim_rd_en=0, busy=0, feat_ready=1, addresses=0.
  - The encoder must also be reset; the scheduler does not resync a partial stream.
- NUM_FOLDS=1 and NUM_CHANNEL=1 are legal. With T=1, OFFER completes the sample directly.

Decomposition:
- Shared package / const.vh: NUM_CHANNEL, NUM_LEVELS, LEVEL_WIDTH, NUM_FOLDS, FOLD_WIDTH, the state enum, and the address-width localparams.
- One sub-module: hv_addr_gen, which holds the channel/fold counters and generates im_addr/cim_addr from the active sample and beat index.

Test Plan:
All scenarios use NUM_CHANNEL=4, NUM_FOLDS=2, FOLD_WIDTH=8, NUM_LEVELS=4, LEVEL_WIDTH=2, with ROM models returning data=addr.

- Single sample, levels {3,0,2,1}, enc_din_ready=1:
  - im_addr sequence 0,2,4,6,1,3,5,7.
  - cim_addr sequence 6,0,4,2,7,1,5,3.
  - enc_din_valid high exactly 1 cycle; 8 consecutive beats; busy drops the cycle after beat 7.
- enc_din_ready low for 5 cycles in OFFER:
  - enc_im held at 0 throughout; rd_en=0.
  - Stream starts the cycle after ready rises.
- Two samples back-to-back (second offered during STREAM):
  - Second is accepted into pending; feat_ready=0 after that.
  - Second sample's PRIME is on the cycle after beat 7, its offer the cycle after that.
  - Third sample is stalled until promotion.
- Feat fire on the completion cycle with pending empty:
  - Sample is not lost; second stream uses the new levels.
- rst_n asserted during beat 3:
  - All outputs go to reset values immediately (asynchronously).
  - After release, a fresh sample restarts from im_addr 0.
- NUM_FOLDS=1, NUM_CHANNEL=1:
  - One beat; scheduler returns to IDLE immediately after the OFFER handshake.

Source files
------------

// File: rtl/spatial_fold_scheduler_pkg.sv
// Shared dimensions, FSM state encoding and width helper for the spatial fold scheduler.
package spatial_fold_scheduler_pkg;

    localparam int unsigned NUM_CHANNEL = 214;
    localparam int unsigned NUM_FOLDS   = 8;
    localparam int unsigned FOLD_WIDTH  = 256;
    localparam int unsigned NUM_LEVELS  = 21;
    localparam int unsigned LEVEL_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_OFFER  = 2'd2,
        ST_STREAM = 2'd3
    } state_e;

    // Index width for a range of n values; a single-entry range still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spatial_fold_scheduler_addr_gen.sv
// hv_addr_gen: fold-major channel/fold counters producing IM and CIM read addresses.
module hv_addr_gen
    import spatial_fold_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CHANNEL = spatial_fold_scheduler_pkg::NUM_CHANNEL,
    parameter int unsigned NUM_FOLDS   = spatial_fold_scheduler_pkg::NUM_FOLDS,
    parameter int unsigned NUM_LEVELS  = spatial_fold_scheduler_pkg::NUM_LEVELS,
    parameter int unsigned LEVEL_WIDTH = spatial_fold_scheduler_pkg::LEVEL_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clear_i,
    input  logic                                     advance_i,
    input  logic [NUM_CHANNEL*LEVEL_WIDTH-1:0]       levels_i,
    output logic [idx_width(NUM_CHANNEL*NUM_FOLDS)-1:0] im_addr_o,
    output logic [idx_width(NUM_LEVELS*NUM_FOLDS)-1:0]  cim_addr_o
);

    localparam int unsigned CH_W   = idx_width(NUM_CHANNEL);
    localparam int unsigned FOLD_W = idx_width(NUM_FOLDS);
    localparam int unsigned IM_AW  = idx_width(NUM_CHANNEL*NUM_FOLDS);
    localparam int unsigned CIM_AW = idx_width(NUM_LEVELS*NUM_FOLDS);

    logic [CH_W-1:0]        ch_q,   ch_d;
    logic [FOLD_W-1:0]      fold_q, fold_d;
    logic [LEVEL_WIDTH-1:0] level_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            fold_q <= '0;
        end else begin
            ch_q   <= ch_d;
            fold_q <= fold_d;
        end
    end

    // Channel is the inner loop; fold advances when the channel wraps.
    always_comb begin
        ch_d   = ch_q;
        fold_d = fold_q;
        if (clear_i) begin
            ch_d   = '0;
            fold_d = '0;
        end else if (advance_i) begin
            if (ch_q == CH_W'(NUM_CHANNEL - 1)) begin
                ch_d   = '0;
                fold_d = (fold_q == FOLD_W'(NUM_FOLDS - 1)) ? '0 : fold_q + FOLD_W'(1);
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
        end
    end

    always_comb begin
        level_c = levels_i[32'(ch_q)*LEVEL_WIDTH +: LEVEL_WIDTH];
    end

    // Arithmetic addressing keeps non-power-of-two dimensions dense.
    always_comb begin
        im_addr_o  = IM_AW'(32'(ch_q) * NUM_FOLDS + 32'(fold_q));
        cim_addr_o = CIM_AW'(32'(level_c) * NUM_FOLDS + 32'(fold_q));
    end

endmodule

// File: rtl/spatial_fold_scheduler.sv
// Sequences one quantized feature sample through the IM/CIM ROMs into spatial_encoder,
// with a one-deep prefetch slot so back-to-back samples only lose the PRIME/OFFER cycles.
module spatial_fold_scheduler
    import spatial_fold_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CHANNEL = spatial_fold_scheduler_pkg::NUM_CHANNEL,
    parameter int unsigned NUM_FOLDS   = spatial_fold_scheduler_pkg::NUM_FOLDS,
    parameter int unsigned FOLD_WIDTH  = spatial_fold_scheduler_pkg::FOLD_WIDTH,
    parameter int unsigned NUM_LEVELS  = spatial_fold_scheduler_pkg::NUM_LEVELS,
    parameter int unsigned LEVEL_WIDTH = spatial_fold_scheduler_pkg::LEVEL_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        feat_valid,
    output logic                                        feat_ready,
    input  logic [NUM_CHANNEL*LEVEL_WIDTH-1:0]          feat_levels,
    output logic                                        im_rd_en,
    output logic [idx_width(NUM_CHANNEL*NUM_FOLDS)-1:0] im_addr,
    input  logic [FOLD_WIDTH-1:0]                       im_data,
    output logic                                        cim_rd_en,
    output logic [idx_width(NUM_LEVELS*NUM_FOLDS)-1:0]  cim_addr,
    input  logic [FOLD_WIDTH-1:0]                       cim_data,
    output logic                                        enc_din_valid,
    input  logic                                        enc_din_ready,
    output logic [FOLD_WIDTH-1:0]                       enc_im,
    output logic [FOLD_WIDTH-1:0]                       enc_cim,
    output logic                                        busy
);

    localparam int unsigned SAMPLE_W  = NUM_CHANNEL * LEVEL_WIDTH;
    localparam int unsigned NUM_BEATS = NUM_CHANNEL * NUM_FOLDS;
    localparam int unsigned BEAT_W    = idx_width(NUM_BEATS);

    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] act_q, act_d;
    logic [SAMPLE_W-1:0] pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic feat_fire_c;
    logic rd_en_c;
    logic ag_clear_c;
    logic done_c;

    assign feat_fire_c = feat_valid && !pend_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            beat_q      <= beat_d;
        end
    end

    // beat_q is the beat currently presented by the ROMs while streaming.
    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        beat_d      = beat_q;
        rd_en_c     = 1'b0;
        ag_clear_c  = 1'b0;
        done_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ag_clear_c = 1'b1;
                beat_d     = '0;
                if (pend_full_q) begin
                    act_d       = pend_q;
                    pend_d      = '0;
                    pend_full_d = 1'b0;
                    state_d     = ST_PRIME;
                end else if (feat_fire_c) begin
                    act_d   = feat_levels;
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                rd_en_c = 1'b1;
                state_d = ST_OFFER;
            end
            ST_OFFER: begin
                if (enc_din_ready) begin
                    if (NUM_BEATS == 1) begin
                        done_c = 1'b1;
                    end else begin
                        rd_en_c = 1'b1;
                        beat_d  = BEAT_W'(1);
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
                    done_c = 1'b1;
                end else begin
                    rd_en_c = 1'b1;
                    beat_d  = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (feat_fire_c && (state_q != ST_IDLE)) begin
            pend_d      = feat_levels;
            pend_full_d = 1'b1;
        end

        // A fire landing on the completion cycle sits in pending and is promoted from IDLE.
        if (done_c) begin
            ag_clear_c = 1'b1;
            beat_d     = '0;
            if (pend_full_q) begin
                act_d       = pend_q;
                pend_d      = '0;
                pend_full_d = 1'b0;
                state_d     = ST_PRIME;
            end else begin
                act_d   = '0;
                state_d = ST_IDLE;
            end
        end
    end

    hv_addr_gen #(
        .NUM_CHANNEL (NUM_CHANNEL),
        .NUM_FOLDS   (NUM_FOLDS),
        .NUM_LEVELS  (NUM_LEVELS),
        .LEVEL_WIDTH (LEVEL_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (ag_clear_c),
        .advance_i  (rd_en_c),
        .levels_i   (act_q),
        .im_addr_o  (im_addr),
        .cim_addr_o (cim_addr)
    );

    assign feat_ready    = !pend_full_q;
    assign im_rd_en      = rd_en_c;
    assign cim_rd_en     = rd_en_c;
    assign enc_din_valid = (state_q == ST_OFFER);
    assign busy          = (state_q != ST_IDLE);
    assign enc_im        = im_data;
    assign enc_cim       = cim_data;

endmodule

// File: tb/tb_spatial_fold_scheduler.sv
// Directed bench for spatial_fold_scheduler: 4ch x 2 folds main instance plus a 1x1 instance.
module tb_spatial_fold_scheduler;

    localparam int T0 = 8;

    logic clk;
    logic rst_n;

    logic       feat_valid;
    logic       feat_ready;
    logic [7:0] feat_levels;
    logic       im_rd_en, cim_rd_en;
    logic [2:0] im_addr, cim_addr;
    logic [7:0] im_data  = '0;
    logic [7:0] cim_data = '0;
    logic       enc_din_valid;
    logic       enc_din_ready;
    logic [7:0] enc_im, enc_cim;
    logic       busy;

    logic       f1_valid;
    logic       f1_ready;
    logic [1:0] f1_levels;
    logic       im1_rd_en, cim1_rd_en;
    logic [0:0] im1_addr;
    logic [1:0] cim1_addr;
    logic [7:0] im1_data  = '0;
    logic [7:0] cim1_data = '0;
    logic       enc1_valid;
    logic       enc1_ready;
    logic [7:0] enc1_im, enc1_cim;
    logic       busy1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int rd_im_q[$];
    int rd_cim_q[$];
    int beat_im_q[$];
    int beat_cim_q[$];
    int beat_cyc_q[$];
    int off_cyc_q[$];
    int valid_cnt = 0;
    int busy_fall = -1;
    bit busy_prev = 1'b0;
    int rem       = 0;

    spatial_fold_scheduler #(
        .NUM_CHANNEL(4), .NUM_FOLDS(2), .FOLD_WIDTH(8), .NUM_LEVELS(4), .LEVEL_WIDTH(2)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .feat_valid    (feat_valid),
        .feat_ready    (feat_ready),
        .feat_levels   (feat_levels),
        .im_rd_en      (im_rd_en),
        .im_addr       (im_addr),
        .im_data       (im_data),
        .cim_rd_en     (cim_rd_en),
        .cim_addr      (cim_addr),
        .cim_data      (cim_data),
        .enc_din_valid (enc_din_valid),
        .enc_din_ready (enc_din_ready),
        .enc_im        (enc_im),
        .enc_cim       (enc_cim),
        .busy          (busy)
    );

    spatial_fold_scheduler #(
        .NUM_CHANNEL(1), .NUM_FOLDS(1), .FOLD_WIDTH(8), .NUM_LEVELS(4), .LEVEL_WIDTH(2)
    ) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .feat_valid    (f1_valid),
        .feat_ready    (f1_ready),
        .feat_levels   (f1_levels),
        .im_rd_en      (im1_rd_en),
        .im_addr       (im1_addr),
        .im_data       (im1_data),
        .cim_rd_en     (cim1_rd_en),
        .cim_addr      (cim1_addr),
        .cim_data      (cim1_data),
        .enc_din_valid (enc1_valid),
        .enc_din_ready (enc1_ready),
        .enc_im        (enc1_im),
        .enc_cim       (enc1_cim),
        .busy          (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: registered, data equals address, held while the strobe is low.
    always @(posedge clk) begin
        if (im_rd_en)   im_data   <= 8'(im_addr);
        if (cim_rd_en)  cim_data  <= 8'(cim_addr);
        if (im1_rd_en)  im1_data  <= 8'(im1_addr);
        if (cim1_rd_en) cim1_data <= 8'(cim1_addr);
    end

    // Encoder-side observer: one handshake beat, then T0-1 unconditional beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            rem = 0;
        end else begin
            if (im_rd_en) begin
                rd_im_q.push_back(int'(im_addr));
                rd_cim_q.push_back(int'(cim_addr));
            end
            if (enc_din_valid) valid_cnt++;
            if (enc_din_valid && enc_din_ready) begin
                beat_im_q.push_back(int'(enc_im));
                beat_cim_q.push_back(int'(enc_cim));
                beat_cyc_q.push_back(cyc);
                off_cyc_q.push_back(cyc);
                rem = T0 - 1;
            end else if (rem > 0) begin
                beat_im_q.push_back(int'(enc_im));
                beat_cim_q.push_back(int'(enc_cim));
                beat_cyc_q.push_back(cyc);
                rem--;
            end
            if (busy_prev && !busy) busy_fall = cyc;
        end
        busy_prev = busy;
    end

    function automatic int exp_im(input int k);
        return (k % 4) * 2 + k / 4;
    endfunction

    function automatic int exp_cim(input logic [7:0] lv, input int k);
        return int'(lv[(k % 4) * 2 +: 2]) * 2 + k / 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] lv, output int fire_cyc);
        bit acc;
        acc      = 1'b0;
        fire_cyc = -1;
        feat_valid  = 1'b1;
        feat_levels = lv;
        for (int i = 0; i < 200; i++) begin
            acc      = feat_ready;
            fire_cyc = cyc;
            tick();
            if (acc) break;
        end
        feat_valid = 1'b0;
        chk("offer_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic chk_stream(input string tag, input int rb, input int bb, input logic [7:0] lv);
        for (int k = 0; k < T0; k++) begin
            chk($sformatf("%s_rd_im%0d", tag, k),   32'(rd_im_q[rb + k]),   32'(exp_im(k)));
            chk($sformatf("%s_rd_cim%0d", tag, k),  32'(rd_cim_q[rb + k]),  32'(exp_cim(lv, k)));
            chk($sformatf("%s_bt_im%0d", tag, k),   32'(beat_im_q[bb + k]), 32'(exp_im(k)));
            chk($sformatf("%s_bt_cim%0d", tag, k),  32'(beat_cim_q[bb + k]), 32'(exp_cim(lv, k)));
        end
    endtask

    initial begin
        int fc, fc2, rb, bb, ob, v0, raise_cyc;
        int im_exp[8];
        int cim_exp[8];
        im_exp  = '{0, 2, 4, 6, 1, 3, 5, 7};
        cim_exp = '{6, 0, 4, 2, 7, 1, 5, 3};

        rst_n = 1'b0;
        feat_valid = 1'b0; feat_levels = '0; enc_din_ready = 1'b1;
        f1_valid = 1'b0; f1_levels = '0; enc1_ready = 1'b1;
        #1;
        chk("rst_feat_ready", 32'(feat_ready), 32'd1);
        chk("rst_busy",       32'(busy), 32'd0);
        chk("rst_valid",      32'(enc_din_valid), 32'd0);
        chk("rst_rd_en",      32'(im_rd_en), 32'd0);
        chk("rst_im_addr",    32'(im_addr), 32'd0);
        chk("rst_cim_addr",   32'(cim_addr), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single sample, levels {3,0,2,1}
        rb = rd_im_q.size(); bb = beat_im_q.size(); v0 = valid_cnt;
        offer(8'h63, fc);
        chk("s1_prime_rd",    32'(im_rd_en), 32'd1);
        chk("s1_prime_cimrd", 32'(cim_rd_en), 32'd1);
        chk("s1_prime_im",    32'(im_addr), 32'd0);
        chk("s1_prime_cim",   32'(cim_addr), 32'd6);
        chk("s1_prime_valid", 32'(enc_din_valid), 32'd0);
        chk("s1_prime_busy",  32'(busy), 32'd1);
        tick();
        chk("s1_offer_valid", 32'(enc_din_valid), 32'd1);
        chk("s1_offer_lat",   32'(cyc), 32'(fc + 2));
        chk("s1_offer_enc_im",  32'(enc_im), 32'd0);
        chk("s1_offer_enc_cim", 32'(enc_cim), 32'd6);
        chk("s1_offer_addr",  32'(im_addr), 32'd2);
        wait_idle();
        chk("s1_nreads", 32'(rd_im_q.size() - rb), 32'd8);
        chk("s1_nbeats", 32'(beat_im_q.size() - bb), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("s1_im_seq%0d", k),  32'(rd_im_q[rb + k]),  32'(im_exp[k]));
            chk($sformatf("s1_cim_seq%0d", k), 32'(rd_cim_q[rb + k]), 32'(cim_exp[k]));
        end
        chk_stream("s1", rb, bb, 8'h63);
        chk("s1_valid_cycles", 32'(valid_cnt - v0), 32'd1);
        chk("s1_consecutive",  32'(beat_cyc_q[bb + 7] - beat_cyc_q[bb]), 32'd7);
        chk("s1_busy_fall",    32'(busy_fall), 32'(beat_cyc_q[bb + 7] + 1));

        // Encoder not ready for 5 cycles in OFFER
        enc_din_ready = 1'b0;
        rb = rd_im_q.size(); bb = beat_im_q.size();
        offer(8'h39, fc);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s2_valid%0d", i),  32'(enc_din_valid), 32'd1);
            chk($sformatf("s2_enc_im%0d", i), 32'(enc_im), 32'd0);
            chk($sformatf("s2_rd_en%0d", i),  32'(im_rd_en), 32'd0);
            tick();
        end
        enc_din_ready = 1'b1;
        raise_cyc = cyc;
        #1;
        chk("s2_rd_on_ready", 32'(im_rd_en), 32'd1);
        wait_idle();
        chk("s2_nbeats",    32'(beat_im_q.size() - bb), 32'd8);
        chk("s2_beat0_cyc", 32'(beat_cyc_q[bb]), 32'(raise_cyc));
        chk("s2_beat1_cyc", 32'(beat_cyc_q[bb + 1]), 32'(raise_cyc + 1));
        chk_stream("s2", rb, bb, 8'h39);

        // Back-to-back samples with a third held off until promotion
        rb = rd_im_q.size(); bb = beat_im_q.size(); ob = off_cyc_q.size();
        offer(8'hE4, fc);
        repeat (3) tick();
        offer(8'h0F, fc2);
        chk("s3_pend_full_ready", 32'(feat_ready), 32'd0);
        chk("s3_b_into_pending",  32'(busy), 32'd1);
        offer(8'hC6, fc2);
        chk("s3_c_fire_at_prime", 32'(fc2), 32'(beat_cyc_q[bb + 7] + 1));
        wait_idle();
        chk("s3_nbeats",   32'(beat_im_q.size() - bb), 32'd24);
        chk("s3_b_offer",  32'(off_cyc_q[ob + 1]), 32'(beat_cyc_q[bb + 7] + 2));
        chk("s3_c_offer",  32'(off_cyc_q[ob + 2]), 32'(beat_cyc_q[bb + 15] + 2));
        chk_stream("s3a", rb,      bb,      8'hE4);
        chk_stream("s3b", rb + 8,  bb + 8,  8'h0F);
        chk_stream("s3c", rb + 16, bb + 16, 8'hC6);

        // Fire on the completion cycle with pending empty
        rb = rd_im_q.size(); bb = beat_im_q.size();
        offer(8'h1B, fc);
        repeat (8) tick();
        chk("s4_beats_before_done", 32'(beat_im_q.size() - bb), 32'd7);
        chk("s4_done_rd_en",        32'(im_rd_en), 32'd0);
        offer(8'hB4, fc2);
        chk("s4_fire_cycle",  32'(fc2), 32'(fc + 9));
        chk("s4_idle_busy",   32'(busy), 32'd0);
        chk("s4_idle_ready",  32'(feat_ready), 32'd0);
        tick();
        chk("s4_prime_busy",  32'(busy), 32'd1);
        chk("s4_prime_rd",    32'(im_rd_en), 32'd1);
        chk("s4_prime_cim",   32'(cim_addr), 32'd0);
        wait_idle();
        chk("s4_nbeats", 32'(beat_im_q.size() - bb), 32'd16);
        chk_stream("s4a", rb,     bb,     8'h1B);
        chk_stream("s4b", rb + 8, bb + 8, 8'hB4);

        // Asynchronous reset during beat 3
        offer(8'h72, fc);
        repeat (4) tick();
        chk("s5_pre_busy", 32'(busy), 32'd1);
        chk("s5_pre_rd",   32'(im_rd_en), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_busy",    32'(busy), 32'd0);
        chk("s5_rst_valid",   32'(enc_din_valid), 32'd0);
        chk("s5_rst_im_rd",   32'(im_rd_en), 32'd0);
        chk("s5_rst_cim_rd",  32'(cim_rd_en), 32'd0);
        chk("s5_rst_ready",   32'(feat_ready), 32'd1);
        chk("s5_rst_im_addr", 32'(im_addr), 32'd0);
        chk("s5_rst_cim_addr", 32'(cim_addr), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rb = rd_im_q.size(); bb = beat_im_q.size();
        offer(8'h63, fc);
        wait_idle();
        chk("s5_nbeats", 32'(beat_im_q.size() - bb), 32'd8);
        chk_stream("s5", rb, bb, 8'h63);

        // Degenerate 1 channel x 1 fold instance
        f1_valid  = 1'b1;
        f1_levels = 2'd2;
        chk("s6_ready", 32'(f1_ready), 32'd1);
        tick();
        f1_valid = 1'b0;
        chk("s6_prime_busy", 32'(busy1), 32'd1);
        chk("s6_prime_rd",   32'(im1_rd_en), 32'd1);
        chk("s6_prime_im",   32'(im1_addr), 32'd0);
        chk("s6_prime_cim",  32'(cim1_addr), 32'd2);
        tick();
        chk("s6_offer_valid", 32'(enc1_valid), 32'd1);
        chk("s6_offer_im",    32'(enc1_im), 32'd0);
        chk("s6_offer_cim",   32'(enc1_cim), 32'd2);
        tick();
        chk("s6_done_busy",  32'(busy1), 32'd0);
        chk("s6_done_valid", 32'(enc1_valid), 32'd0);
        chk("s6_done_ready", 32'(f1_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
